// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and the core.
//   master : fetch unit side (drives memory request and core-facing instruction)
//   slave  : environment side (memory responder plus the core's redirect/ready)
// Signals:
//   redirect/redirect_pc                        core -> fetch, PC change
//   mem_req/mem_addr                            fetch -> memory, request
//   mem_ack/mem_rvalid/mem_rdata                memory -> fetch, accept/response
//   instr_valid/instr/instr_pc                  fetch -> core, FIFO head
//   instr_ready                                 core -> fetch, consume head
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one-at-a-time requests to a multi-cycle
// instruction memory, buffers responses in a DEPTH-entry prefetch FIFO and
// presents the head to the core with valid/ready. A redirect flushes the FIFO
// and marks any in-flight response as stale.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fetch_unit_if.master (memory request/response, core handshake)
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] fetch_pc, pc_nxt, req_addr;
  logic [PW:0]      count, count_nxt;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             mem_req;
  logic             accept, push, pop;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];

  // mem_req is only ever high in FETCH, so an ack without it is ignored.
  assign accept = mem_req && bus.mem_ack;
  assign push   = (state == WAIT) && bus.mem_rvalid && !bus.redirect;
  assign pop    = (count != '0) && bus.instr_ready && !bus.redirect;

  always_comb begin
    state_nxt = state;
    pc_nxt    = fetch_pc;
    count_nxt = count;
    if (bus.redirect) begin
      count_nxt = '0;
      pc_nxt    = {bus.redirect_pc[WIDTH-1:2], 2'b00};
      // Any accepted-but-unanswered request is stale; a response landing this
      // cycle is simply dropped.
      case (state)
        FETCH:       state_nxt = accept ? DRAIN : FETCH;
        WAIT, DRAIN: state_nxt = bus.mem_rvalid ? FETCH : DRAIN;
        default:     state_nxt = FETCH;
      endcase
    end else begin
      count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
      case (state)
        FETCH: if (accept) begin
          state_nxt = WAIT;
          pc_nxt    = fetch_pc + WIDTH'(4);
        end
        WAIT, DRAIN: if (bus.mem_rvalid) state_nxt = FETCH;
        default:     state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      mem_req  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
      count    <= count_nxt;
      // Registered request: only FETCH with room (nothing is outstanding there).
      mem_req  <= (state_nxt == FETCH) && (count_nxt < FULL);
      if (accept) req_addr <= fetch_pc;
      if (bus.redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.mem_rdata;
      pc_q[wr_ptr]   <= req_addr;
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = (count != '0) ? data_q[rd_ptr] : '0;
  assign bus.instr_pc    = (count != '0) ? pc_q[rd_ptr]   : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based behavioural model of the
// prefetch stream plus a responding instruction memory, directed scenarios
// and a randomized soak.
module tb_fetch_unit;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_unit_if #(.WIDTH(WIDTH)) bus ();

  fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  // Model state
  entry_t      q[$];
  logic [31:0] m_pc, m_req_addr;
  bit          m_out, m_stale, m_fresh, in_reset;

  // Memory responder state
  bit          mem_pending;
  int unsigned mem_cd;
  logic [31:0] mem_raddr;
  int unsigned acc_count;
  logic [31:0] last_acc_addr;

  // Stimulus knobs: 0 = low, 1 = high, 2 = random
  int unsigned ack_mode, ready_mode, lat_mode;
  bit          rand_redir, spur_en, redir_next;
  logic [31:0] redir_pc_next;

  int unsigned n_pass, n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
  endtask

  function automatic bit req_now();
    return !m_fresh && !in_reset && !m_out && (q.size() < int'(DEPTH));
  endfunction

  function automatic logic pick(input int unsigned mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic compare();
    logic [31:0] e_instr, e_pc;
    e_instr = 32'h0;
    e_pc    = 32'h0;
    if (q.size() != 0) begin
      e_instr = q[0].data;
      e_pc    = q[0].pc;
    end
    chk("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
    chk("instr", bus.instr, e_instr);
    chk("instr_pc", bus.instr_pc, e_pc);
    chk("mem_req", 32'(bus.mem_req), 32'(req_now()));
    if (req_now() || in_reset) chk("mem_addr", bus.mem_addr, m_pc);
  endtask

  // Advance the model across the coming rising edge, using the driven inputs.
  task automatic model_update(output bit accepted);
    entry_t e;
    accepted = req_now() && bus.mem_ack;
    if (bus.redirect) begin
      q.delete();
      if (m_out) begin
        if (bus.mem_rvalid) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end else if (accepted) begin
        m_out = 1; m_stale = 1;
      end
      m_pc = bus.redirect_pc & ~32'h3;
    end else begin
      if (q.size() != 0 && bus.instr_ready) void'(q.pop_front());
      if (m_out && bus.mem_rvalid) begin
        if (!m_stale) begin
          e.data = bus.mem_rdata;
          e.pc   = m_req_addr;
          q.push_back(e);
        end
        m_out = 0; m_stale = 0;
      end else if (!m_out && accepted) begin
        m_out = 1; m_stale = 0;
        m_req_addr = m_pc;
        m_pc = m_pc + 32'h4;
      end
    end
    m_fresh = 0;
  endtask

  task automatic tick();
    bit          acc;
    logic [31:0] addr_now;
    @(negedge clk);
    compare();
    bus.mem_ack     = pick(ack_mode);
    bus.instr_ready = pick(ready_mode);
    bus.redirect    = 1'b0;
    bus.redirect_pc = $urandom;
    if (redir_next) begin
      bus.redirect    = 1'b1;
      bus.redirect_pc = redir_pc_next;
      redir_next      = 0;
    end else if (rand_redir && $urandom_range(0, 11) == 0) begin
      bus.redirect    = 1'b1;
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom);
    end
    if (mem_pending && mem_cd == 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_raddr ^ 32'hA5A5_0000;
      mem_pending    = 0;
    end else begin
      bus.mem_rvalid = spur_en && !mem_pending && !m_out && ($urandom_range(0, 15) == 0);
      bus.mem_rdata  = $urandom;
      if (mem_pending) mem_cd--;
    end
    addr_now = m_pc;
    model_update(acc);
    if (acc) begin
      mem_pending   = 1;
      mem_raddr     = addr_now;
      mem_cd        = (lat_mode == 0) ? 0 : (lat_mode == 1) ? 2 : $urandom_range(0, 2);
      acc_count++;
      last_acc_addr = addr_now;
    end
  endtask

  task automatic do_reset();
    bit a;
    @(negedge clk);
    rst = 1'b0;
    in_reset = 1;
    bus.mem_ack = 0; bus.mem_rvalid = 0; bus.redirect = 0;
    bus.instr_ready = 0; bus.redirect_pc = '0; bus.mem_rdata = '0;
    q.delete();
    m_out = 0; m_stale = 0; m_fresh = 1; m_pc = RESET_PC;
    acc_count = 0; redir_next = 0;
    #1 compare();
    repeat (2) begin
      @(negedge clk);
      compare();
    end
    rst = 1'b1;
    in_reset = 0;
    model_update(a);
  endtask

  task automatic wait_valid(input string name);
    int unsigned k = 0;
    while (!bus.instr_valid && k < 60) begin tick(); k++; end
    if (!bus.instr_valid) timeout(name);
  endtask

  task automatic wait_acc(input int unsigned n, input string name);
    int unsigned k = 0;
    while (acc_count < n && k < 60) begin tick(); k++; end
    if (acc_count < n) timeout(name);
  endtask

  initial begin
    int unsigned k;
    n_pass = 0; n_total = 0;
    bus.mem_ack = 0; bus.mem_rvalid = 0; bus.redirect = 0;
    bus.instr_ready = 0; bus.redirect_pc = '0; bus.mem_rdata = '0;
    mem_pending = 0; mem_cd = 0; mem_raddr = '0; last_acc_addr = '0;
    m_req_addr = '0; rand_redir = 0; spur_en = 0; redir_pc_next = '0;

    // In-order delivery from a 1-cycle memory
    ack_mode = 1; ready_mode = 0; lat_mode = 0;
    do_reset();
    wait_valid("t1_first_valid");
    chk("t1_instr0", bus.instr, 32'hA5A5_0000);
    chk("t1_pc0", bus.instr_pc, 32'h0);
    ready_mode = 1; tick(); ready_mode = 0; tick();
    wait_valid("t1_second_valid");
    chk("t1_instr1", bus.instr, 32'hA5A5_0004);
    chk("t1_pc1", bus.instr_pc, 32'h4);

    // Fill the FIFO, then free one slot
    do_reset();
    ack_mode = 1; ready_mode = 0; lat_mode = 0;
    repeat (30) tick();
    chk("t2_req_count", acc_count, 32'd4);
    chk("t2_mem_req_full", 32'(bus.mem_req), 32'd0);
    chk("t2_valid_full", 32'(bus.instr_valid), 32'd1);
    ready_mode = 1; tick(); ready_mode = 0; tick();
    chk("t2_mem_req_after_pop", 32'(bus.mem_req), 32'd1);
    chk("t2_addr_after_pop", bus.mem_addr, 32'h10);

    // Redirect while waiting on 0x8
    do_reset();
    ack_mode = 1; ready_mode = 1; lat_mode = 1;
    wait_acc(3, "t3_acc_8");
    chk("t3_waiting_addr", last_acc_addr, 32'h8);
    redir_next = 1; redir_pc_next = 32'h103;
    tick();
    wait_acc(4, "t3_acc_100");
    chk("t3_next_req", last_acc_addr, 32'h100);
    wait_valid("t3_valid");
    chk("t3_first_pc", bus.instr_pc, 32'h100);

    // Redirect coinciding with rvalid and instr_ready
    do_reset();
    ack_mode = 1; ready_mode = 0; lat_mode = 0;
    k = 0;
    while (!(q.size() >= 1 && mem_pending && mem_cd == 0) && k < 60) begin tick(); k++; end
    if (!(q.size() >= 1 && mem_pending && mem_cd == 0)) timeout("t4_setup");
    redir_next = 1; redir_pc_next = 32'h200; ready_mode = 1;
    tick();
    ready_mode = 0;
    tick();
    chk("t4_flushed", 32'(bus.instr_valid), 32'd0);
    chk("t4_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t4_mem_addr", bus.mem_addr, 32'h200);

    // Redirect on an unaccepted request
    do_reset();
    ack_mode = 0; ready_mode = 0; lat_mode = 0;
    tick(); tick();
    redir_next = 1; redir_pc_next = 32'h301;
    tick(); tick();
    chk("t5_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t5_mem_addr", bus.mem_addr, 32'h300);
    ack_mode = 1;
    wait_valid("t5_valid");
    chk("t5_first_pc", bus.instr_pc, 32'h300);

    // Reset pulse during WAIT with a late response after release
    do_reset();
    ack_mode = 1; ready_mode = 0; lat_mode = 1;
    wait_acc(3, "t6_acc_8");
    ack_mode = 0;
    do_reset();
    mem_pending = 1; mem_cd = 1; mem_raddr = 32'h8;
    tick(); tick(); tick();
    chk("t6_late_ignored", 32'(bus.instr_valid), 32'd0);
    ack_mode = 1;
    wait_valid("t6_valid");
    chk("t6_first_pc", bus.instr_pc, RESET_PC);
    chk("t6_first_instr", bus.instr, RESET_PC ^ 32'hA5A5_0000);

    // Randomized soak
    do_reset();
    mem_pending = 0;
    ack_mode = 2; ready_mode = 2; lat_mode = 2; rand_redir = 1; spur_en = 1;
    repeat (4000) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
